// File: rtl/edge_pkg.sv
// Shared definitions for the 3x3 edge-gradient block: kernel selector
// encoding and the width rules for the gradient and magnitude datapaths.
// No ports; imported by edge_grad_3x3, edge_win_3x3.
package edge_pkg;

  // cfg_mode encoding: 0 selects Prewitt weights (1,1,1), 1 selects Sobel (1,2,1).
  typedef enum logic {
    PREWITT = 1'b0,
    SOBEL   = 1'b1
  } kernel_e;

  // A weighted column sum peaks at 4*(2^pix_w-1), which needs pix_w+2 bits,
  // so a signed difference of two of them fits in pix_w+3 bits.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // |GX|+|GY| peaks at 8*(2^pix_w-1); pix_w+4 bits holds it with headroom.
  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/edge_grad_3x3_if.sv
// Pixel-column stream into and gradient stream out of edge_grad_3x3.
// Signals: in_valid/in_sof/in_row0..2/cfg_mode (source side),
// out_valid/out_mag/out_eol (result side); thresh only with EDGE_GRAD_THRESH_EN.
interface edge_grad_3x3_if #(
  parameter int PIX_W = 8
);

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_row0;
  logic [PIX_W-1:0] in_row1;
  logic [PIX_W-1:0] in_row2;
  logic             cfg_mode;
`ifdef EDGE_GRAD_THRESH_EN
  logic [PIX_W-1:0] thresh;
`endif
  logic             out_valid;
  logic [PIX_W-1:0] out_mag;
  logic             out_eol;

  // Driver of pixel columns / consumer of results.
  modport master (
`ifdef EDGE_GRAD_THRESH_EN
    output thresh,
`endif
    output in_valid, in_sof, in_row0, in_row1, in_row2, cfg_mode,
    input  out_valid, out_mag, out_eol
  );

  // The gradient block itself.
  modport slave (
`ifdef EDGE_GRAD_THRESH_EN
    input  thresh,
`endif
    input  in_valid, in_sof, in_row0, in_row1, in_row2, cfg_mode,
    output out_valid, out_mag, out_eol
  );

endinterface

// File: rtl/edge_win_3x3.sv
// 3x3 pixel window and column counter: shifts one column per in_valid.
// Latency: window and win_vld/win_eol update on the accepting edge.
// No backpressure: every in_valid column is taken.
// Ports: clk, rst (async active-high); in_valid, in_sof, in_row0..2 in;
// win[row][col] (col 0 = oldest/left, col 2 = newest/right), win_vld
// (accepted column index >= 2), win_eol (accepted column was IMG_W-1) out.
module edge_win_3x3
  import edge_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [PIX_W-1:0]           in_row0,
  input  logic [PIX_W-1:0]           in_row1,
  input  logic [PIX_W-1:0]           in_row2,
  output logic [2:0][2:0][PIX_W-1:0] win,
  output logic                       win_vld,
  output logic                       win_eol
);

  localparam int            CW   = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);

  logic [CW-1:0]              col_q, col_d, col_cur;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic                       win_vld_q, win_vld_d;
  logic                       win_eol_q, win_eol_d;

  always_comb begin
    // in_sof forces this column to index 0 whatever the counter says,
    // so a row can restart at any point.
    col_cur   = in_sof ? '0 : col_q;
    col_d     = col_q;
    win_d     = win_q;
    win_vld_d = 1'b0;
    win_eol_d = 1'b0;
    if (in_valid) begin
      col_d = (col_cur == LAST) ? '0 : col_cur + CW'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = in_row0;
      win_d[1][2] = in_row1;
      win_d[2][2] = in_row2;
      // Only from column 2 on does the window hold three columns of this row.
      win_vld_d   = (col_cur >= CW'(2));
      win_eol_d   = (col_cur == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
      win_eol_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      win_eol_q <= win_eol_d;
    end
  end

  assign win     = win_q;
  assign win_vld = win_vld_q;
  assign win_eol = win_eol_q;

endmodule

// File: rtl/edge_grad_3x3.sv
// 3x3 Prewitt/Sobel gradient magnitude |GX|+|GY| over a column stream.
// Latency: result registered 2 edges after the accepting edge.
// No backpressure: pipeline advances every cycle, in_valid gaps are free.
// Ports: clk, rst (async active-high); bus (edge_grad_3x3_if.slave):
// in_valid, in_sof, in_row0..2, cfg_mode in; out_valid, out_mag, out_eol out.
// Build option EDGE_GRAD_THRESH_EN: adds bus.thresh and outputs all-ones
// when mag >= thresh, else 0, instead of the saturated magnitude.
module edge_grad_3x3
  import edge_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic           clk,
  input  logic           rst,
  edge_grad_3x3_if.slave bus
);

  localparam int GW = grad_w(PIX_W);
  localparam int MW = mag_w(PIX_W);

  logic [2:0][2:0][PIX_W-1:0] win;
  logic                       win_vld;
  logic                       win_eol;

  edge_win_3x3 #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_win (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_sof   (bus.in_sof),
    .in_row0  (bus.in_row0),
    .in_row1  (bus.in_row1),
    .in_row2  (bus.in_row2),
    .win      (win),
    .win_vld  (win_vld),
    .win_eol  (win_eol)
  );

  // The centre pixel has zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^win[1][1];

  // Weighted sum of three pixels; the middle one is doubled for Sobel.
  function automatic logic [GW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c,
                                         input logic             sobel);
    logic [GW-1:0] mid;
    mid = sobel ? (GW'(b) << 1) : GW'(b);
    return GW'(a) + mid + GW'(c);
  endfunction

  // Stage 1: gradients. cfg_mode is sampled here, one edge after the
  // column was accepted.
  logic                 sobel;
  logic [GW-1:0]        r_sum, l_sum, t_sum, b_sum;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic                 s1_vld_q, s1_vld_d, s1_eol_q, s1_eol_d;

  always_comb begin
    sobel    = (kernel_e'(bus.cfg_mode) == SOBEL);
    r_sum    = wsum(win[0][2], win[1][2], win[2][2], sobel);
    l_sum    = wsum(win[0][0], win[1][0], win[2][0], sobel);
    t_sum    = wsum(win[0][0], win[0][1], win[0][2], sobel);
    b_sum    = wsum(win[2][0], win[2][1], win[2][2], sobel);
    gx_d     = gx_q;
    gy_d     = gy_q;
    s1_vld_d = win_vld;
    s1_eol_d = win_eol;
    if (win_vld) begin
      // Sums are below 2^(GW-1), so they are non-negative as signed values.
      gx_d = $signed(r_sum) - $signed(l_sum);
      gy_d = $signed(t_sum) - $signed(b_sum);
    end
  end

  // Stage 2: magnitude and output formatting.
  logic [GW-1:0]    abs_gx, abs_gy;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] pix_res;
  logic [PIX_W-1:0] out_mag_q, out_mag_d;
  logic             out_valid_q, out_valid_d;
  logic             out_eol_q, out_eol_d;

`ifndef EDGE_GRAD_THRESH_EN
  localparam logic [MW-1:0] PIX_MAX = MW'((2 ** PIX_W) - 1);
`endif

  always_comb begin
    abs_gx = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_gy = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag    = MW'(abs_gx) + MW'(abs_gy);
`ifdef EDGE_GRAD_THRESH_EN
    pix_res = (mag >= MW'(bus.thresh)) ? '1 : '0;
`else
    pix_res = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
`endif
    out_valid_d = s1_vld_q;
    out_eol_d   = s1_vld_q & s1_eol_q;
    // out_mag holds its last result between output pulses.
    out_mag_d   = s1_vld_q ? pix_res : out_mag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q        <= '0;
      gy_q        <= '0;
      s1_vld_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      out_mag_q   <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      s1_vld_q    <= s1_vld_d;
      s1_eol_q    <= s1_eol_d;
      out_mag_q   <= out_mag_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_eol   = out_eol_q;

endmodule

// File: tb/tb_edge_grad_3x3.sv
// Directed bench for edge_grad_3x3 (PIX_W=8, IMG_W=8).
// Each cycle carries the hand-computed result its column must produce;
// that result is compared exactly two cycles later, idle cycles check hold.
module tb_edge_grad_3x3;

  typedef logic [7:0] row_t [8];
  typedef struct packed {
    logic       v;
    logic [7:0] m;
    logic       e;
  } exp_t;

  localparam exp_t IDLE = '{v: 1'b0, m: 8'd0, e: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       hist [3];
  logic [7:0] last_mag;
  string      phase;

  edge_grad_3x3_if #(.PIX_W(8)) bus ();

  edge_grad_3x3 #(
    .PIX_W (8),
    .IMG_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic row_t fill(input logic [7:0] v);
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  // Columns 0-3 = a, 4-7 = b.
  function automatic row_t step_row(input logic [7:0] a, input logic [7:0] b);
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = (i < 4) ? a : b;
    return r;
  endfunction

  // Expected magnitudes when columns 2 and 3 give 0.
  function automatic row_t em_row(input logic [7:0] c4, input logic [7:0] c5,
                                  input logic [7:0] c6, input logic [7:0] c7);
    row_t r;
    r = fill(8'd0);
    r[4] = c4; r[5] = c5; r[6] = c6; r[7] = c7;
    return r;
  endfunction

  // Threshold build (thresh = 31) turns any magnitude into 0 or 255.
  function automatic logic [7:0] conv(input logic [7:0] v);
`ifdef EDGE_GRAD_THRESH_EN
    return (v >= 8'd31) ? 8'hFF : 8'h00;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, expv);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) hist[i] = IDLE;
    last_mag = 8'd0;
  endtask

  // One cycle: drive at the falling edge, check at the next falling edge.
  task automatic cyc(input logic v, input logic sof, input logic mode,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input exp_t cur);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.cfg_mode = mode;
    bus.in_row0  = a;
    bus.in_row1  = b;
    bus.in_row2  = c;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = cur;
    @(negedge clk);
    chk("out_valid", {7'd0, bus.out_valid}, {7'd0, hist[2].v});
    if (hist[2].v) begin
      chk("out_mag", bus.out_mag, hist[2].m);
      chk("out_eol", {7'd0, bus.out_eol}, {7'd0, hist[2].e});
      last_mag = hist[2].m;
    end else begin
      chk("out_mag_hold", bus.out_mag, last_mag);
      chk("out_eol_idle", {7'd0, bus.out_eol}, 8'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, bus.cfg_mode, 8'd0, 8'd0, 8'd0, IDLE);
  endtask

  // Send columns 0..n-1 of a row; mode_msk bit i is cfg_mode while column i
  // is driven and during the gap cycles after it.
  task automatic send_row(input logic sof, input logic [7:0] mode_msk,
                          input int n, input int gap,
                          input row_t t, input row_t m, input row_t b, input row_t em);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v = (i >= 2);
      e.m = (i >= 2) ? conv(em[i]) : 8'd0;
      e.e = (i == 7);
      cyc(1'b1, sof && (i == 0), mode_msk[i], t[i], m[i], b[i], e);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, mode_msk[i], t[i], m[i], b[i], IDLE);
    end
  endtask

  // Outputs must clear as soon as rst rises, before any clock edge.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_out_mag", bus.out_mag, 8'd0);
    chk("rst_out_eol", {7'd0, bus.out_eol}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_hist();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.cfg_mode = 1'b0;
    bus.in_row0  = 8'd0;
    bus.in_row1  = 8'd0;
    bus.in_row2  = 8'd0;
`ifdef EDGE_GRAD_THRESH_EN
    bus.thresh   = 8'd31;
`endif
    clear_hist();
    #2;
    phase = "reset";
    do_reset();

    phase = "flat100";
    send_row(1'b1, 8'h00, 8, 0, fill(8'd100), fill(8'd100), fill(8'd100), fill(8'd0));

    phase = "step_prewitt";
    send_row(1'b1, 8'h00, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), em_row(8'd30, 8'd30, 8'd0, 8'd0));

    phase = "step_sobel_wrap";
    send_row(1'b0, 8'hFF, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), em_row(8'd40, 8'd40, 8'd0, 8'd0));

    phase = "rows_50_35_20";
    send_row(1'b0, 8'hFF, 8, 0, fill(8'd50), fill(8'd35), fill(8'd20), fill(8'd120));

    phase = "sat_pos";
    send_row(1'b1, 8'hFF, 8, 0, step_row(8'd0, 8'd255), step_row(8'd0, 8'd255),
             step_row(8'd0, 8'd255), em_row(8'd255, 8'd255, 8'd0, 8'd0));

    phase = "sat_neg";
    send_row(1'b1, 8'h00, 8, 0, step_row(8'd255, 8'd0), step_row(8'd255, 8'd0),
             step_row(8'd255, 8'd0), em_row(8'd255, 8'd255, 8'd0, 8'd0));

    phase = "gx_plus_gy";
    send_row(1'b1, 8'h00, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             fill(8'd10), em_row(8'd30, 8'd40, 8'd30, 8'd30));

    phase = "mode_switch";
    send_row(1'b1, 8'hC0, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), em_row(8'd30, 8'd40, 8'd0, 8'd0));

    phase = "partial_row_gaps";
    send_row(1'b1, 8'h00, 5, 3, fill(8'd100), fill(8'd100), fill(8'd100), fill(8'd0));
    phase = "midrow_sof_gaps";
    send_row(1'b1, 8'h00, 8, 3, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), em_row(8'd30, 8'd30, 8'd0, 8'd0));

    phase = "pre_reset_row";
    send_row(1'b1, 8'h00, 4, 0, fill(8'd100), fill(8'd100), fill(8'd100), fill(8'd0));
    phase = "midrow_reset";
    do_reset();
    phase = "after_reset_row";
    send_row(1'b0, 8'h00, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), em_row(8'd30, 8'd30, 8'd0, 8'd0));

`ifdef EDGE_GRAD_THRESH_EN
    phase = "thresh_below";
    send_row(1'b1, 8'h00, 8, 0, step_row(8'd10, 8'd20), step_row(8'd10, 8'd20),
             step_row(8'd10, 8'd20), fill(8'd0));
    phase = "thresh_above";
    send_row(1'b1, 8'h00, 8, 0, step_row(8'd10, 8'd21), step_row(8'd10, 8'd21),
             step_row(8'd10, 8'd21), em_row(8'd255, 8'd255, 8'd0, 8'd0));
`endif

    phase = "drain";
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
